bicolour_led_pwm: RTL and testbench

Parametrised successor to the bicolour LED multiplex driver. Each of N_LEDS anti-parallel bicolour LEDs sits on one tristate pin. The block time-multiplexes the two colours and gives each colour an independent PWM intensity, instead of fixed on/off/blend levels. A register-style write port loads a shadow intensity table, and a commit request transfers it atomically to the live table at the next frame boundary, so the display never tears. Pin outputs are split into value and output-enable so the top level can instantiate its tristate buffers.

---
 rtl/bicolour_led_pwm.sv | 167 ++++++++++++++++
 tb/tb_bicolour_led_pwm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicolour_led_pwm.sv
// Bicolour LED PWM driver: each tristate pin alternates colour A (driven 0) and colour B
// (driven 1) with independent PWM duty, fed from a live table committed at frame boundaries.
module bicolour_led_pwm #(
    parameter int N_LEDS     = 12,
    parameter int PWM_BITS   = 8,
    parameter int DEAD_TICKS = 2,
    parameter int PRESCALE   = 1,
    parameter int ADDR_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [PWM_BITS-1:0]  wr_duty_a,
    input  logic [PWM_BITS-1:0]  wr_duty_b,
    input  logic                 commit,
    output logic                 commit_pending,
    output logic                 frame_start,
    output logic [N_LEDS-1:0]    led_o,
    output logic [N_LEDS-1:0]    led_oe
);

    localparam int PHASE_LEN = DEAD_TICKS + (1 << PWM_BITS);
    localparam int POS_W     = $clog2(PHASE_LEN);
    localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(PHASE_LEN - 1);
    localparam logic [POS_W-1:0]   POS_DEAD  = POS_W'(DEAD_TICKS);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [ADDR_BITS:0] ADDR_LIMIT = (ADDR_BITS + 1)'(N_LEDS);

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    typedef struct packed {
        logic [PWM_BITS-1:0] a;
        logic [PWM_BITS-1:0] b;
    } duty_t;

    logic [PRE_W-1:0]  r_pre;
    logic              w_tick;
    phase_t            r_phase;
    phase_t            w_phase_nxt;
    logic [POS_W-1:0]  r_pos;
    logic [POS_W-1:0]  w_pos_nxt;
    logic              w_copy_edge;
    logic              w_copy;
    logic              w_wr_ok;
    logic              r_pending;
    duty_t             r_shadow [N_LEDS];
    duty_t             r_live   [N_LEDS];
    logic              w_dead;
    logic [PWM_BITS-1:0] w_c;
    logic [N_LEDS-1:0] w_oe_nxt;
    logic [N_LEDS-1:0] w_o_nxt;
    logic [N_LEDS-1:0] r_led_oe;
    logic [N_LEDS-1:0] r_led_o;
    logic              r_frame_start;

    // Prescaler: one tick every PRESCALE clocks (constant high when PRESCALE is 1).
    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_A;
            r_pos   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_pos_nxt   = r_pos;
        if (w_tick) begin
            if (r_pos == POS_LAST) begin
                w_pos_nxt   = '0;
                w_phase_nxt = (r_phase == PH_A) ? PH_B : PH_A;
            end else begin
                w_pos_nxt = r_pos + POS_W'(1);
            end
        end
    end

    // The B->A wrap is the only point where the live table may change.
    assign w_copy_edge = w_tick && (r_phase == PH_B) && (r_pos == POS_LAST);
    assign w_copy      = w_copy_edge && (r_pending || commit);
    assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < ADDR_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: both tables are real flops with reset, so a reset leaves every LED dark
            // and a commit right after reset copies zeros rather than stale intensities.
            for (int i = 0; i < N_LEDS; i++) begin
                r_shadow[i] <= '0;
                r_live[i]   <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the copy read the shadow value from before
            // this edge, so a write landing on the copy edge stays in shadow only.
            for (int i = 0; i < N_LEDS; i++) begin
                if (w_wr_ok && (wr_addr == ADDR_BITS'(i))) begin
                    r_shadow[i] <= {wr_duty_a, wr_duty_b};
                end
                if (w_copy) begin
                    r_live[i] <= r_shadow[i];
                end
            end
            if (w_copy_edge) begin
                r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_dead = (r_pos < POS_DEAD);
    assign w_c    = PWM_BITS'(r_pos - POS_DEAD);

    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        w_oe_nxt = '0;
        w_o_nxt  = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (!w_dead) begin
                if (r_phase == PH_A) begin
                    w_oe_nxt[i] = (w_c < r_live[i].a);
                end else begin
                    w_oe_nxt[i] = (w_c < r_live[i].b);
                    w_o_nxt[i]  = w_oe_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_oe      <= '0;
            r_led_o       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_led_oe      <= w_oe_nxt;
            r_led_o       <= w_o_nxt;
            r_frame_start <= (r_phase == PH_A) && (r_pos == '0) && (r_pre == '0);
        end
    end

    assign led_oe         = r_led_oe;
    assign led_o          = r_led_o;
    assign frame_start    = r_frame_start;
    assign commit_pending = r_pending;

endmodule

// File: tb/tb_bicolour_led_pwm.sv
// Scoreboard bench for bicolour_led_pwm: per-frame expected pin patterns are queued up front
// and a negedge monitor captures each frame from frame_start and compares it.
module tb_bicolour_led_pwm;

    localparam int NL = 4;
    localparam int PB = 4;
    localparam int DT = 2;
    localparam int AB = 4;
    localparam int FR = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [PB-1:0] wr_duty_a;
    logic [PB-1:0] wr_duty_b;
    logic          commit;
    logic          commit_pending;
    logic          frame_start;
    logic [NL-1:0] led_o;
    logic [NL-1:0] led_oe;

    logic          rst3;
    logic          wr_en3;
    logic [AB-1:0] wr_addr3;
    logic [PB-1:0] wr_duty_a3;
    logic [PB-1:0] wr_duty_b3;
    logic          commit3;
    logic          commit_pending3;
    logic          frame_start3;
    logic [NL-1:0] led_o3;
    logic [NL-1:0] led_oe3;

    always #5 clk = ~clk;

    bicolour_led_pwm #(
        .N_LEDS(NL), .PWM_BITS(PB), .DEAD_TICKS(DT), .PRESCALE(1), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_duty_a(wr_duty_a), .wr_duty_b(wr_duty_b), .commit(commit),
        .commit_pending(commit_pending), .frame_start(frame_start),
        .led_o(led_o), .led_oe(led_oe)
    );

    bicolour_led_pwm #(
        .N_LEDS(NL), .PWM_BITS(PB), .DEAD_TICKS(DT), .PRESCALE(3), .ADDR_BITS(AB)
    ) dut3 (
        .clk(clk), .rst(rst3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_duty_a(wr_duty_a3), .wr_duty_b(wr_duty_b3), .commit(commit3),
        .commit_pending(commit_pending3), .frame_start(frame_start3),
        .led_o(led_o3), .led_oe(led_oe3)
    );

    typedef struct {
        int                     epoch;
        int                     frame;
        string                  name;
        logic [NL-1:0][FR-1:0]  oe;
        logic [NL-1:0][FR-1:0]  o;
        logic [FR-1:0]          pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   exp_a[NL];
    int   exp_b[NL];
    int   pcnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Bits [start, start+len) set; phase A window starts at cycle 2, phase B at 18+2 = 20.
    function automatic logic [FR-1:0] win(input int start, input int len);
        return ((FR'(1) << len) - FR'(1)) << start;
    endfunction

    task automatic push_frame(input int ep, input int fr, input string name,
                              input int p_lo, input int p_hi);
        exp_t e;
        e.epoch = ep;
        e.frame = fr;
        e.name  = name;
        for (int ch = 0; ch < NL; ch++) begin
            e.oe[ch] = win(2, exp_a[ch]) | win(20, exp_b[ch]);
            e.o[ch]  = win(20, exp_b[ch]);
        end
        e.pend = (p_lo < 0) ? '0 : win(p_lo, p_hi - p_lo + 1);
        sb_q.push_back(e);
    endtask

    // Clock edges since the last reset release; edge p shows frame cycle (p-1) mod 36.
    always @(posedge clk or posedge rst) begin
        if (rst) pcnt <= 0;
        else     pcnt <= pcnt + 1;
    end

    int                    mon_epoch  = 0;
    int                    mon_frame  = -1;
    int                    mon_k      = 0;
    bit                    mon_in_rst = 1'b0;
    bit                    mon_busy   = 1'b0;
    logic [NL-1:0][FR-1:0] cap_oe;
    logic [NL-1:0][FR-1:0] cap_o;
    logic [FR-1:0]         cap_pend;
    logic [FR-1:0]         cap_fs;

    task automatic score_frame();
        exp_t e;
        while (sb_q.size() > 0 && (sb_q[0].epoch < mon_epoch ||
               (sb_q[0].epoch == mon_epoch && sb_q[0].frame < mon_frame))) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: frame %0d of epoch %0d never observed, now at %0d",
                     sb_q[0].name, sb_q[0].frame, sb_q[0].epoch, mon_frame);
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].epoch == mon_epoch && sb_q[0].frame == mon_frame) begin
            e = sb_q.pop_front();
            for (int ch = 0; ch < NL; ch++) begin
                check($sformatf("%s ch%0d oe", e.name, ch), 64'(cap_oe[ch]), 64'(e.oe[ch]));
                check($sformatf("%s ch%0d o", e.name, ch), 64'(cap_o[ch]), 64'(e.o[ch]));
            end
            check($sformatf("%s pending", e.name), 64'(cap_pend), 64'(e.pend));
            check($sformatf("%s frame_start", e.name), 64'(cap_fs), 64'(FR'(1)));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!mon_in_rst) mon_epoch++;
            mon_in_rst = 1'b1;
            mon_busy   = 1'b0;
            mon_frame  = -1;
        end else begin
            mon_in_rst = 1'b0;
            if (!mon_busy && frame_start) begin
                mon_busy = 1'b1;
                mon_k    = 0;
                mon_frame++;
            end
            if (mon_busy) begin
                for (int ch = 0; ch < NL; ch++) begin
                    cap_oe[ch][mon_k] = led_oe[ch];
                    cap_o[ch][mon_k]  = led_o[ch];
                end
                cap_pend[mon_k] = commit_pending;
                cap_fs[mon_k]   = frame_start;
                mon_k++;
                if (mon_k == FR) begin
                    mon_busy = 1'b0;
                    score_frame();
                end
            end
        end
    end

    task automatic goto(input int f, input int k);
        int target = f * FR + k;
        int guard  = 0;
        while (pcnt != target && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (pcnt != target) check("goto_timeout", 64'(pcnt), 64'(target));
    endtask

    task automatic do_write(input int addr, input int a, input int b, input bit with_commit);
        wr_en     = 1'b1;
        wr_addr   = AB'(addr);
        wr_duty_a = PB'(a);
        wr_duty_b = PB'(b);
        commit    = with_commit;
        @(negedge clk);
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1);
    end

    initial begin
        int  first;
        int  last;
        int  cnt;
        int  other;
        int  ohigh;
        bit  seen;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_duty_a = '0; wr_duty_b = '0; commit = 1'b0;
        rst3 = 1'b1; wr_en3 = 1'b0; wr_addr3 = '0; wr_duty_a3 = '0; wr_duty_b3 = '0; commit3 = 1'b0;
        for (int ch = 0; ch < NL; ch++) begin
            exp_a[ch] = 0;
            exp_b[ch] = 0;
        end

        // Epoch 1 plan: live table contents seen in each frame, with commit_pending windows.
        push_frame(1, 0, "dark_then_commit", 5, 34);
        exp_a[0] = 4; exp_a[1] = 15; exp_b[1] = 8;
        push_frame(1, 1, "single_and_blend", -1, -1);
        push_frame(1, 2, "shadow_iso_f2", -1, -1);
        push_frame(1, 3, "shadow_iso_f3", -1, -1);
        push_frame(1, 4, "shadow_iso_commit", 10, 34);
        exp_a[2] = 9;
        push_frame(1, 5, "shadow_copied", -1, -1);
        exp_a[0] = 6;
        push_frame(1, 6, "collision_copy", 12, 34);
        exp_a[3] = 5;
        push_frame(1, 7, "second_commit", 4, 34);
        push_frame(1, 8, "out_of_range", -1, -1);

        // Epoch 2 plan: after a mid-frame reset everything is zero, including the shadow.
        for (int ch = 0; ch < NL; ch++) begin
            exp_a[ch] = 0;
            exp_b[ch] = 0;
        end
        push_frame(2, 0, "dark_after_reset", -1, -1);
        push_frame(2, 1, "commit_empty_shadow", 3, 34);
        push_frame(2, 2, "shadow_cleared", 3, 34);
        exp_a[0] = 4;
        push_frame(2, 3, "rewrite_after_reset", -1, -1);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        goto(0, 3);  do_write(0, 4, 0, 1'b0);
        goto(0, 4);  do_write(1, 15, 8, 1'b0);
        goto(0, 5);  do_commit();
        goto(1, 7);  do_write(2, 9, 0, 1'b0);
        goto(4, 10); do_commit();
        goto(5, 20); do_write(0, 6, 0, 1'b0);
        goto(5, 35); do_write(3, 5, 0, 1'b1);
        goto(6, 12); do_commit();
        goto(7, 2);  do_write(4, 15, 15, 1'b0);
        goto(7, 3);  do_write(7, 15, 15, 1'b0);
        goto(7, 4);  do_commit();
        goto(9, 2);  do_write(1, 3, 3, 1'b0);
        goto(9, 5);  do_commit();

        // Frame 9 cycle 20: phase B pos 2, only ch1 (b=8) drives high.
        goto(9, 21);
        check("pre_reset led_oe", 64'(led_oe), 64'(4'b0010));
        check("pre_reset led_o", 64'(led_o), 64'(4'b0010));
        check("pre_reset pending", 64'(commit_pending), 64'(1));
        rst = 1'b1;
        #1;
        check("reset led_oe", 64'(led_oe), 64'(0));
        check("reset led_o", 64'(led_o), 64'(0));
        check("reset pending", 64'(commit_pending), 64'(0));
        check("reset frame_start", 64'(frame_start), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        goto(1, 3);  do_commit();
        goto(2, 2);  do_write(0, 4, 0, 1'b0);
        goto(2, 3);  do_commit();
        goto(4, 2);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        // PRESCALE=3: ch0 a=4 drives on pos 2..5, i.e. clk cycles 6..17 of a 108-clk frame.
        @(negedge clk);
        rst3 = 1'b0;
        wr_en3 = 1'b1; wr_addr3 = AB'(0); wr_duty_a3 = PB'(4); wr_duty_b3 = PB'(0);
        @(negedge clk);
        wr_en3 = 1'b0;
        commit3 = 1'b1;
        @(negedge clk);
        commit3 = 1'b0;
        check("p3 pending", 64'(commit_pending3), 64'(1));
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (frame_start3) seen = 1'b1;
        end
        check("p3 frame_start seen", 64'(seen), 64'(1));
        if (seen) begin
            check("p3 pending cleared", 64'(commit_pending3), 64'(0));
            first = -1; last = -1; cnt = 0; other = 0; ohigh = 0;
            for (int k = 0; k < 108; k++) begin
                if (led_oe3[0]) begin
                    cnt++;
                    if (first < 0) first = k;
                    last = k;
                end
                if (led_oe3[3:1] != 3'b000) other++;
                if (led_o3 != '0) ohigh++;
                @(negedge clk);
            end
            check("p3 active count", 64'(cnt), 64'(12));
            check("p3 first active", 64'(first), 64'(6));
            check("p3 last active", 64'(last), 64'(17));
            check("p3 other channels", 64'(other), 64'(0));
            check("p3 led_o high", 64'(ohigh), 64'(0));
            check("p3 frame period", 64'(frame_start3), 64'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
